// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEFAULT_MEM_DEPTH = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// port that did not win last time.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    // Pure combinational pick; the caller records the winner as last_grant.
    always_comb begin
        valid  = req_a | req_b;
        winner = PORT_A;
        if (req_a && req_b) begin
            winner = ~last_grant;
        end else if (req_b) begin
            winner = PORT_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port DMem.
// One access per grant: IDLE latches the winner, ACCESS drives memory,
// RESP presents a one-cycle Ack to the owner.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = DEFAULT_MEM_DEPTH
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     A_Req,
    input  logic                     A_Wr,
    input  logic [ADDRESS_WIDTH-1:0] A_Addr,
    input  logic [DATA_WIDTH-1:0]    A_WData,
    output logic                     A_Ack,
    output logic [DATA_WIDTH-1:0]    A_RData,
    output logic                     A_Err,
    input  logic                     B_Req,
    input  logic                     B_Wr,
    input  logic [ADDRESS_WIDTH-1:0] B_Addr,
    input  logic [DATA_WIDTH-1:0]    B_WData,
    output logic                     B_Ack,
    output logic [DATA_WIDTH-1:0]    B_RData,
    output logic                     B_Err,
    output logic [ADDRESS_WIDTH-1:0] Mem_Address,
    output logic [DATA_WIDTH-1:0]    Mem_WriteData,
    output logic                     Mem_MemWrite,
    input  logic [DATA_WIDTH-1:0]    Mem_MemData,
    output logic                     Busy,
    output logic                     Grant
);

    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(MEM_DEPTH);

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     wr_q, wr_d;
    logic                     err_q, err_d;
    logic                     owner_q, owner_d;
    logic                     last_grant_q, last_grant_d;
    logic                     a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic                     a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATA_WIDTH-1:0]    a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                     arb_valid, arb_winner;
    logic [DATA_WIDTH-1:0]    rdata_cap;

    rr_arb2 u_rr_arb2 (
        .req_a      (A_Req),
        .req_b      (B_Req),
        .last_grant (last_grant_q),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    // Out-of-range reads return zero instead of whatever the memory drives.
    assign rdata_cap = err_q ? '0 : Mem_MemData;

    // Next-state, command latch and response computation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        err_d        = err_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_err_d      = 1'b0;
        b_err_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_d      = arb_winner;
                    last_grant_d = arb_winner;
                    if (arb_winner == PORT_B) begin
                        addr_d  = B_Addr;
                        wdata_d = B_WData;
                        wr_d    = B_Wr;
                        err_d   = (B_Addr >= DEPTH_A);
                    end else begin
                        addr_d  = A_Addr;
                        wdata_d = A_WData;
                        wr_d    = A_Wr;
                        err_d   = (A_Addr >= DEPTH_A);
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Ack/Err registered here so they are visible exactly during RESP.
                if (owner_q == PORT_B) begin
                    b_ack_d = 1'b1;
                    b_err_d = err_q;
                    if (!wr_q) b_rdata_d = rdata_cap;
                end else begin
                    a_ack_d = 1'b1;
                    a_err_d = err_q;
                    if (!wr_q) a_rdata_d = rdata_cap;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight access.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            owner_q      <= PORT_A;
            last_grant_q <= PORT_B;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_err_q      <= a_err_d;
            b_err_q      <= b_err_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign Mem_Address   = addr_q;
    assign Mem_WriteData = wdata_q;
    assign Mem_MemWrite  = (state_q == ACCESS) & wr_q & ~err_q;
    assign Busy          = (state_q == ACCESS) | (state_q == RESP);
    assign Grant         = owner_q;
    assign A_Ack         = a_ack_q;
    assign A_Err         = a_err_q;
    assign A_RData       = a_rdata_q;
    assign B_Ack         = b_ack_q;
    assign B_Err         = b_err_q;
    assign B_RData       = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural DMem attached.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        A_Req = 1'b0, A_Wr = 1'b0;
    logic [31:0] A_Addr = '0, A_WData = '0;
    logic        B_Req = 1'b0, B_Wr = 1'b0;
    logic [31:0] B_Addr = '0, B_WData = '0;
    logic        A_Ack, A_Err, B_Ack, B_Err;
    logic [31:0] A_RData, B_RData;
    logic [31:0] Mem_Address, Mem_WriteData, Mem_MemData;
    logic        Mem_MemWrite, Busy, Grant;

    int total = 0;
    int bad   = 0;

    // Memory is 64 deep so a stray out-of-range write lands somewhere visible.
    logic [31:0] mem [64];
    logic        mem_init = 1'b1;
    logic        wr_seen  = 1'b0;
    logic        wr_seen_clr = 1'b0;

    always #5 Clk = ~Clk;

    assign Mem_MemData = mem[Mem_Address[5:0]];

    // Memory write port plus a sticky flag of any write strobe.
    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (Mem_MemWrite) begin
            mem[Mem_Address[5:0]] <= Mem_WriteData;
        end
        if (wr_seen_clr)       wr_seen <= 1'b0;
        else if (Mem_MemWrite) wr_seen <= 1'b1;
    end

    dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .A_Req(A_Req), .A_Wr(A_Wr), .A_Addr(A_Addr), .A_WData(A_WData),
        .A_Ack(A_Ack), .A_RData(A_RData), .A_Err(A_Err),
        .B_Req(B_Req), .B_Wr(B_Wr), .B_Addr(B_Addr), .B_WData(B_WData),
        .B_Ack(B_Ack), .B_RData(B_RData), .B_Err(B_Err),
        .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
        .Mem_MemWrite(Mem_MemWrite), .Mem_MemData(Mem_MemData),
        .Busy(Busy), .Grant(Grant)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        step(); step();
        mem_init = 1'b0;
        Rst_n = 1'b1;
        total++; if ({A_Ack, A_Err, B_Ack, B_Err, Busy, Grant, Mem_MemWrite} !== 7'b0) begin
            bad++; $display("FAIL reset_flags got %b want 0", {A_Ack, A_Err, B_Ack, B_Err, Busy, Grant, Mem_MemWrite}); end
        total++; if ({A_RData, B_RData, Mem_Address, Mem_WriteData} !== 128'b0) begin
            bad++; $display("FAIL reset_buses got %h want 0", {A_RData, B_RData, Mem_Address, Mem_WriteData}); end
        // A write to addr 3, then reset lands in the middle of ACCESS.
        A_Req = 1'b1; A_Wr = 1'b1; A_Addr = 32'd3; A_WData = 32'h3333_3333;
        step();
        total++; if (Mem_MemWrite !== 1'b1) begin
            bad++; $display("FAIL rst_access_wr got %b want 1", Mem_MemWrite); end
        Rst_n = 1'b0;
        #1;
        total++; if (Mem_MemWrite !== 1'b0 || Busy !== 1'b0) begin
            bad++; $display("FAIL rst_async_abort got wr=%b busy=%b want 0 0", Mem_MemWrite, Busy); end
        A_Req = 1'b0; A_Wr = 1'b0; A_Addr = '0; A_WData = '0;
        step(); step();
        Rst_n = 1'b1;
        step();
        total++; if (mem[3] !== 32'hA000_0003) begin
            bad++; $display("FAIL rst_mem3 got %h want a0000003", mem[3]); end
        total++; if ({A_Ack, A_Err, B_Ack, B_Err, Busy, Grant, Mem_MemWrite, A_RData, Mem_Address} !== 71'b0) begin
            bad++; $display("FAIL rst_outputs got ack=%b busy=%b rdata=%h addr=%h want 0", A_Ack, Busy, A_RData, Mem_Address); end
    endtask

    task automatic test_tie();
        A_Req = 1'b1; A_Wr = 1'b0; A_Addr = 32'd1;
        B_Req = 1'b1; B_Wr = 1'b1; B_Addr = 32'd2; B_WData = 32'h0000_1234;
        step();
        total++; if (Grant !== 1'b0 || Busy !== 1'b1 || Mem_Address !== 32'd1 || Mem_MemWrite !== 1'b0) begin
            bad++; $display("FAIL tie_first_grant got g=%b busy=%b addr=%h wr=%b want 0 1 1 0", Grant, Busy, Mem_Address, Mem_MemWrite); end
        step();
        total++; if (A_Ack !== 1'b1 || B_Ack !== 1'b0 || A_RData !== 32'hA000_0001 || A_Err !== 1'b0) begin
            bad++; $display("FAIL tie_a_ack got ack=%b/%b rdata=%h err=%b want 1/0 a0000001 0", A_Ack, B_Ack, A_RData, A_Err); end
        A_Req = 1'b0;
        step();
        total++; if (Busy !== 1'b0 || A_Ack !== 1'b0) begin
            bad++; $display("FAIL tie_idle got busy=%b ack=%b want 0 0", Busy, A_Ack); end
        step();
        total++; if (Grant !== 1'b1 || Mem_MemWrite !== 1'b1 || Mem_Address !== 32'd2 || Mem_WriteData !== 32'h1234) begin
            bad++; $display("FAIL tie_second_grant got g=%b wr=%b addr=%h wd=%h want 1 1 2 1234", Grant, Mem_MemWrite, Mem_Address, Mem_WriteData); end
        step();
        total++; if (B_Ack !== 1'b1 || A_Ack !== 1'b0 || B_Err !== 1'b0) begin
            bad++; $display("FAIL tie_b_ack got b=%b a=%b err=%b want 1 0 0", B_Ack, A_Ack, B_Err); end
        B_Req = 1'b0; B_Wr = 1'b0;
        step();
        total++; if (mem[2] !== 32'h0000_1234) begin
            bad++; $display("FAIL tie_mem2 got %h want 00001234", mem[2]); end
    endtask

    task automatic test_alternate();
        logic order [$];
        logic exp_order [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   both = 0;
        A_Req = 1'b1; A_Wr = 1'b0; A_Addr = 32'd0;
        B_Req = 1'b1; B_Wr = 1'b0; B_Addr = 32'd1;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            step();
            if (A_Ack && B_Ack) both++;
            if (A_Ack) order.push_back(1'b0);
            if (B_Ack) order.push_back(1'b1);
        end
        A_Req = 1'b0; B_Req = 1'b0;
        total++; if (order.size() != 6) begin
            bad++; $display("FAIL alt_count got %0d want 6", order.size()); end
        total++; if (both != 0) begin
            bad++; $display("FAIL alt_double_ack got %0d want 0", both); end
        for (int k = 0; k < 6 && k < order.size(); k++) begin
            total++; if (order[k] !== exp_order[k]) begin
                bad++; $display("FAIL alt_order[%0d] got %b want %b", k, order[k], exp_order[k]); end
        end
        step();
    endtask

    task automatic test_write_read();
        A_Req = 1'b1; A_Wr = 1'b1; A_Addr = 32'd5; A_WData = 32'hDEAD_BEEF;
        step();
        total++; if (Mem_MemWrite !== 1'b1 || Mem_Address !== 32'd5 || Mem_WriteData !== 32'hDEAD_BEEF || A_Ack !== 1'b0) begin
            bad++; $display("FAIL wr_access got wr=%b addr=%h wd=%h ack=%b", Mem_MemWrite, Mem_Address, Mem_WriteData, A_Ack); end
        step();
        total++; if (A_Ack !== 1'b1 || A_Err !== 1'b0 || Mem_MemWrite !== 1'b0) begin
            bad++; $display("FAIL wr_ack got ack=%b err=%b wr=%b want 1 0 0", A_Ack, A_Err, Mem_MemWrite); end
        A_Req = 1'b0;
        step();
        A_Req = 1'b1; A_Wr = 1'b0;
        step(); step();
        total++; if (A_Ack !== 1'b1 || A_RData !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_back got ack=%b rdata=%h want 1 deadbeef", A_Ack, A_RData); end
        A_Req = 1'b0;
        step();
        total++; if (A_Ack !== 1'b0 || A_RData !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_hold got ack=%b rdata=%h want 0 deadbeef", A_Ack, A_RData); end
    endtask

    task automatic test_oob();
        wr_seen_clr = 1'b1; step(); wr_seen_clr = 1'b0;
        B_Req = 1'b1; B_Wr = 1'b1; B_Addr = 32'd32; B_WData = 32'h5555_5555;
        step(); step();
        total++; if (B_Ack !== 1'b1 || B_Err !== 1'b1 || A_Ack !== 1'b0 || A_Err !== 1'b0) begin
            bad++; $display("FAIL oob_wr_ack got ack=%b err=%b a=%b%b want 1 1 00", B_Ack, B_Err, A_Ack, A_Err); end
        B_Req = 1'b0;
        step();
        total++; if (wr_seen !== 1'b0 || mem[32] !== 32'hA000_0020) begin
            bad++; $display("FAIL oob_no_write got seen=%b mem32=%h want 0 a0000020", wr_seen, mem[32]); end
        total++; if (B_Err !== 1'b0) begin
            bad++; $display("FAIL oob_err_clear got %b want 0", B_Err); end
        B_Req = 1'b1; B_Wr = 1'b0; B_Addr = 32'd40;
        step(); step();
        total++; if (B_Ack !== 1'b1 || B_Err !== 1'b1 || B_RData !== 32'h0) begin
            bad++; $display("FAIL oob_rd got ack=%b err=%b rdata=%h want 1 1 0", B_Ack, B_Err, B_RData); end
        B_Req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'd4, 32'd6, 32'd7};
        B_Req = 1'b1; B_Wr = 1'b0; B_Addr = addrs[0];
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (Grant !== 1'b1 || Busy !== 1'b1 || B_Ack !== 1'b0 || A_Ack !== 1'b0) begin
                bad++; $display("FAIL b2b_access[%0d] got g=%b busy=%b ack=%b%b want 1 1 00", k, Grant, Busy, A_Ack, B_Ack); end
            step();
            total++; if (B_Ack !== 1'b1 || A_Ack !== 1'b0 || B_RData !== 32'hA000_0000 + addrs[k]) begin
                bad++; $display("FAIL b2b_ack[%0d] got ack=%b a=%b rdata=%h want 1 0 %h", k, B_Ack, A_Ack, B_RData, 32'hA000_0000 + addrs[k]); end
            if (k < 2) B_Addr = addrs[k+1];
            else       B_Req = 1'b0;
            step();
        end
        total++; if (Busy !== 1'b0 || B_Ack !== 1'b0) begin
            bad++; $display("FAIL b2b_end got busy=%b ack=%b want 0 0", Busy, B_Ack); end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_alternate();
        test_write_read();
        test_oob();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
